int_bus_arbiter: RTL

Two-master arbiter for the internal register-file bus (int_address / int_wr_data / int_write / int_read / int_rd_data).
- Master 0 is normally uart2bus_top; master 1 is a local controller.
- Each master uses a req/ack handshake. The arbiter serialises accesses and issues single-cycle int_write / int_read strobes.
- For reads, it waits the register file's read latency, then returns the data to the winning master.

---
 rtl/int_bus_arbiter_pkg.sv | 19 +
 rtl/int_bus_pick.sv | 21 ++
 rtl/int_bus_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/int_bus_arbiter_pkg.sv
// Shared definitions for the two-master register-file bus arbiter:
// FSM state encodings, picker mode and default bus widths.
package int_bus_arbiter_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = 3;  // wide enough for RD_LAT up to 4

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic {
    PICK_FIXED = 1'b0,
    PICK_RR    = 1'b1
  } pick_mode_t;
endpackage

// File: rtl/int_bus_pick.sv
// Combinational 2-way picker: a lone request wins; on a tie, round-robin mode
// grants the master that was not served last, fixed mode always grants master 0.
module int_bus_pick
  import int_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  pick_mode_t mode,
  output logic       gnt_vld,
  output logic       winner
);
  always_comb begin
    gnt_vld = |req;
    winner  = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = (mode == PICK_RR) ? ~last : 1'b0;
      default: winner = 1'b0;
    endcase
  end
endmodule

// File: rtl/int_bus_arbiter.sv
// Two-master req/ack arbiter for the internal register-file bus.
// Define INT_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 has priority.
module int_bus_arbiter
  import int_bus_arbiter_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] int_address,
  output logic [DW-1:0] int_wr_data,
  output logic          int_write,
  output logic          int_read,
  input  logic [DW-1:0] int_rd_data,
  output logic          busy,
  output logic          owner
);
  logic [1:0]         req;
  logic [1:0]         we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic [1:0]         ack;
  logic [1:0][DW-1:0] rdata;

  assign req      = {m1_req, m0_req};
  assign we       = {m1_we, m0_we};
  assign addr     = {m1_addr, m0_addr};
  assign wdata    = {m1_wdata, m0_wdata};
  assign m0_ack   = ack[0];
  assign m1_ack   = ack[1];
  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cur_we;
  logic             last;
  logic             gnt_vld;
  logic             winner;

`ifdef INT_ARB_ROUND_ROBIN_EN
  localparam pick_mode_t MODE = PICK_RR;
  // Reset to 1 so master 0 takes the first tie.
  always_ff @(posedge clock) begin
    if (reset)                          last <= 1'b1;
    else if (state == ST_IDLE && gnt_vld) last <= winner;
  end
`else
  localparam pick_mode_t MODE = PICK_FIXED;
  assign last = 1'b1;
`endif

  int_bus_pick u_pick (
    .req     (req),
    .last    (last),
    .mode    (MODE),
    .gnt_vld (gnt_vld),
    .winner  (winner)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE:  if (gnt_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (cur_we) state_nxt = ST_ACK;
        else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(RD_LAT);
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = ST_ACK;
      end
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes line up with ISSUE
  // and acks with ACK.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur_we      <= 1'b0;
      ack         <= '0;
      rdata       <= '0;
      int_address <= '0;
      int_wr_data <= '0;
      int_write   <= 1'b0;
      int_read    <= 1'b0;
      busy        <= 1'b0;
      owner       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt != ST_IDLE);
      int_write <= 1'b0;
      int_read  <= 1'b0;
      ack       <= '0;
      if (state == ST_IDLE && gnt_vld) begin
        owner       <= winner;
        cur_we      <= we[winner];
        int_address <= addr[winner];
        int_wr_data <= wdata[winner];
        int_write   <= we[winner];
        int_read    <= ~we[winner];
      end
      if (state == ST_WAIT && cnt == CNT_W'(1)) rdata[owner] <= int_rd_data;
      if (state_nxt == ST_ACK) ack[owner] <= 1'b1;
    end
  end
endmodule
